psram_qspi_emu: RTL and testbench

Synthesizable, clk-oversampled emulator of a quad-SPI/QPI PSRAM device. It lets FPGA and gate-level benches of the KianV SoC run against a PSRAM without a vendor model. The host-side bus pins (sck, ce_n, dio) are sampled on the system clock, decoded by a command FSM, and served from an internal byte array. Beyond the earlier behavioural model, it adds:
- QPI mode
- configurable dummy cycles
- page-wrap addressing
- reset-enable/reset command pair
- split dio_in/dio_out/dio_oe pins for synthesis

---
 rtl/psram_emu_pkg.sv | 35 +++
 rtl/psram_emu_mem.sv | 30 +++
 rtl/psram_qspi_emu.sv | 270 +++++++++++++++++++++++++++
 tb/tb_psram_qspi_emu.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_emu_pkg.sv
// rtl/psram_emu_pkg.sv - opcodes, FSM states and address helper for the PSRAM emulator
package psram_emu_pkg;

  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;
  localparam logic [7:0] CMD_RST_EN    = 8'h66;
  localparam logic [7:0] CMD_RST       = 8'h99;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } state_e;

  // Burst address advance: wraps inside a page, or linearly over the array when page_bytes is 0.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [31:0] page_bytes,
                                            input logic [31:0] mem_bytes);
    logic [31:0] inc;
    inc = addr + 32'd1;
    if (page_bytes != 32'd0) begin
      next_addr = ((addr & ~(page_bytes - 32'd1)) | (inc & (page_bytes - 32'd1)))
                  & (mem_bytes - 32'd1);
    end else begin
      next_addr = inc & (mem_bytes - 32'd1);
    end
  endfunction

endpackage

// File: rtl/psram_emu_mem.sv
// rtl/psram_emu_mem.sv - byte-wide simple dual-port RAM with one-clock read latency
module psram_emu_mem #(
  parameter int unsigned MEM_BYTES = 65536,
  localparam int unsigned AW = $clog2(MEM_BYTES)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [MEM_BYTES];
  logic [7:0] rdata_q;

  // Array is never cleared; read data is only updated on a read request so it holds for the bus.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/psram_qspi_emu.sv
// rtl/psram_qspi_emu.sv - clk-oversampled quad-SPI/QPI PSRAM device emulator
module psram_qspi_emu
  import psram_emu_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 65536,
  parameter int unsigned PAGE_BYTES   = 1024,
  parameter int unsigned DUMMY_CYCLES = 6,
  parameter bit          QPI_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_in,
  output logic [3:0] dio_out,
  output logic       dio_oe,
  output logic       qpi_mode
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  // Synchroniser and edge-detect registers
  logic       sck_meta_q, sck_sync_q, sck_prev_q;
  logic       ce_meta_q, ce_sync_q, ce_prev_q;
  logic [3:0] dio_meta_q, dio_sync_q;
  logic       sck_rise, sck_fall, ce_fall, ce_rise;

  // Protocol state
  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [7:0]    sh_q, sh_d, cmd_byte;
  logic [AW-1:0] addr_q, addr_d, addr_shift, addr_next;
  logic [3:0]    hi_q, hi_d;
  logic          have_hi_q, have_hi_d;
  logic          lo_next_q, lo_next_d;
  logic          pf_pend_q, pf_pend_d;
  logic          qpi_q, qpi_d;
  logic          rst_en_q, rst_en_d;
  logic          pend66_q, pend66_d;
  logic [3:0]    dio_out_q, dio_out_d;
  logic          dio_oe_q, dio_oe_d;

  // Array port signals
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [7:0]    mem_wdata, mem_rdata;

  // Two-flop synchronisers plus a delayed copy for one-clk edge strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_meta_q <= 1'b0;
      sck_sync_q <= 1'b0;
      sck_prev_q <= 1'b0;
      ce_meta_q  <= 1'b1;
      ce_sync_q  <= 1'b1;
      ce_prev_q  <= 1'b1;
      dio_meta_q <= 4'h0;
      dio_sync_q <= 4'h0;
    end else begin
      sck_meta_q <= sck;
      sck_sync_q <= sck_meta_q;
      sck_prev_q <= sck_sync_q;
      ce_meta_q  <= ce_n;
      ce_sync_q  <= ce_meta_q;
      ce_prev_q  <= ce_sync_q;
      dio_meta_q <= dio_in;
      dio_sync_q <= dio_meta_q;
    end
  end

  assign sck_rise = sck_sync_q & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q;
  assign ce_fall  = ~ce_sync_q & ce_prev_q;
  assign ce_rise  = ce_sync_q & ~ce_prev_q;

  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign cmd_byte   = qpi_q ? {sh_q[3:0], dio_sync_q} : {sh_q[6:0], dio_sync_q[0]};
  assign addr_shift = {addr_q[AW-5:0], dio_sync_q};
  assign addr_next  = AW'(next_addr(32'(addr_q), PAGE_BYTES, MEM_BYTES));

  // Protocol state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      sh_q      <= 8'd0;
      addr_q    <= '0;
      hi_q      <= 4'h0;
      have_hi_q <= 1'b0;
      lo_next_q <= 1'b0;
      pf_pend_q <= 1'b0;
      qpi_q     <= 1'b0;
      rst_en_q  <= 1'b0;
      pend66_q  <= 1'b0;
      dio_out_q <= 4'h0;
      dio_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      have_hi_q <= have_hi_d;
      lo_next_q <= lo_next_d;
      pf_pend_q <= pf_pend_d;
      qpi_q     <= qpi_d;
      rst_en_q  <= rst_en_d;
      pend66_q  <= pend66_d;
      dio_out_q <= dio_out_d;
      dio_oe_q  <= dio_oe_d;
    end
  end

  // Next-state decode: chip select dominates, then per-state handling of sck edges
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    have_hi_d = have_hi_q;
    lo_next_d = lo_next_q;
    pf_pend_d = pf_pend_q;
    qpi_d     = qpi_q;
    rst_en_d  = rst_en_q;
    pend66_d  = pend66_q;
    dio_out_d = dio_out_q;
    dio_oe_d  = dio_oe_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = {hi_q, dio_sync_q};
    mem_re    = 1'b0;
    mem_raddr = addr_q;

    if (ce_sync_q) begin
      // Deselected: a half-received byte is simply dropped with have_hi
      state_d   = IDLE;
      dio_oe_d  = 1'b0;
      have_hi_d = 1'b0;
      if (ce_rise && pend66_q) begin
        rst_en_d = 1'b1;
      end
    end else if (ce_fall) begin
      state_d   = CMD;
      cnt_d     = 8'd0;
      sh_d      = 8'd0;
      have_hi_d = 1'b0;
      lo_next_d = 1'b0;
      pf_pend_d = 1'b0;
      pend66_d  = 1'b0;
      dio_oe_d  = 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          dio_oe_d = 1'b0;
          if (sck_rise) begin
            sh_d  = cmd_byte;
            cnt_d = cnt_inc;
            if (cnt_q == (qpi_q ? 8'd1 : 8'd7)) begin
              cnt_d    = 8'd0;
              state_d  = IGNORE;
              rst_en_d = 1'b0;
              case (cmd_byte)
                CMD_QREAD:     state_d = ADDR;
                CMD_QWRITE:    state_d = ADDR;
                CMD_QPI_ENTER: if (QPI_EN) qpi_d = 1'b1;
                CMD_QPI_EXIT:  if (QPI_EN && qpi_q) qpi_d = 1'b0;
                CMD_RST_EN: begin
                  rst_en_d = rst_en_q;
                  pend66_d = 1'b1;
                end
                CMD_RST:       if (rst_en_q) qpi_d = 1'b0;
                default:       ;
              endcase
            end
          end
        end
        ADDR: begin
          dio_oe_d = 1'b0;
          if (sck_rise) begin
            addr_d = addr_shift;
            cnt_d  = cnt_inc;
            if (cnt_q == 8'd5) begin
              cnt_d     = 8'd0;
              have_hi_d = 1'b0;
              state_d   = (sh_q == CMD_QREAD) ? DUMMY : WRITE;
            end
          end
        end
        DUMMY: begin
          dio_oe_d = 1'b0;
          if (sck_rise) begin
            cnt_d = cnt_inc;
            if (cnt_q == 8'(DUMMY_CYCLES - 1)) begin
              cnt_d     = 8'd0;
              mem_re    = 1'b1;
              mem_raddr = addr_q;
              lo_next_d = 1'b0;
              pf_pend_d = 1'b0;
              state_d   = READ;
            end
          end
        end
        READ: begin
          cnt_d = cnt_inc;
          if (sck_fall) begin
            dio_oe_d = 1'b1;
            if (!lo_next_q) begin
              dio_out_d = mem_rdata[7:4];
              lo_next_d = 1'b1;
            end else begin
              dio_out_d = mem_rdata[3:0];
              lo_next_d = 1'b0;
              pf_pend_d = 1'b1;
            end
          end
          // Prefetch on the rise that samples the low nibble so the next fall has data
          if (sck_rise && pf_pend_q) begin
            mem_re    = 1'b1;
            mem_raddr = addr_next;
            addr_d    = addr_next;
            pf_pend_d = 1'b0;
          end
        end
        WRITE: begin
          dio_oe_d = 1'b0;
          if (sck_rise) begin
            if (!have_hi_q) begin
              hi_d      = dio_sync_q;
              have_hi_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              mem_waddr = addr_q;
              mem_wdata = {hi_q, dio_sync_q};
              addr_d    = addr_next;
              have_hi_d = 1'b0;
            end
          end
        end
        IGNORE: begin
          dio_oe_d = 1'b0;
        end
        IDLE: begin
          dio_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          dio_oe_d = 1'b0;
        end
      endcase
    end
  end

  psram_emu_mem #(
    .MEM_BYTES(MEM_BYTES)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (mem_re),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign dio_out  = dio_out_q;
  assign dio_oe   = dio_oe_q;
  assign qpi_mode = qpi_q;

endmodule

// File: tb/tb_psram_qspi_emu.sv
// tb/tb_psram_qspi_emu.sv - scoreboard bench for the PSRAM emulator (paged, linear and no-QPI builds)
module tb_psram_qspi_emu;

  localparam int DUMMY = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sck = 1'b0;
  logic [2:0] ce_n_v = 3'b111;
  logic [3:0] dio_b = 4'h0;

  logic [3:0] out0, out1, out2;
  logic       oe0, oe1, oe2;
  logic       qpi0, qpi1, qpi2;

  logic [3:0] sel_out;
  logic       sel_oe, sel_qpi;

  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic bqpi [3] = '{1'b0, 1'b0, 1'b0};

  logic [7:0] mdl [0:2][0:65535];
  logic [7:0] exp_q [$];
  logic [7:0] wbuf [$];

  always #5 clk = ~clk;

  psram_qspi_emu u_dut0 (
    .clk(clk), .resetn(resetn), .sck(sck), .ce_n(ce_n_v[0]), .dio_in(dio_b),
    .dio_out(out0), .dio_oe(oe0), .qpi_mode(qpi0)
  );

  psram_qspi_emu #(.PAGE_BYTES(0)) u_dut1 (
    .clk(clk), .resetn(resetn), .sck(sck), .ce_n(ce_n_v[1]), .dio_in(dio_b),
    .dio_out(out1), .dio_oe(oe1), .qpi_mode(qpi1)
  );

  psram_qspi_emu #(.QPI_EN(1'b0)) u_dut2 (
    .clk(clk), .resetn(resetn), .sck(sck), .ce_n(ce_n_v[2]), .dio_in(dio_b),
    .dio_out(out2), .dio_oe(oe2), .qpi_mode(qpi2)
  );

  always_comb begin
    sel_out = out0;
    sel_oe  = oe0;
    sel_qpi = qpi0;
    if (sel == 1) begin
      sel_out = out1; sel_oe = oe1; sel_qpi = qpi1;
    end else if (sel == 2) begin
      sel_out = out2; sel_oe = oe2; sel_qpi = qpi2;
    end
  end

  // Expected burst order: instance 1 is linear, the others wrap in 1 KiB pages
  function automatic int model_next(input int inst, input int a);
    if (inst == 1) return (a + 1) % 65536;
    return (a / 1024) * 1024 + ((a % 1024) + 1) % 1024;
  endfunction

  task automatic sck_cycle(input logic [3:0] nib);
    dio_b = nib;
    repeat (5) @(negedge clk);
    sck = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic begin_txn();
    ce_n_v[sel] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic end_txn();
    repeat (3) @(negedge clk);
    ce_n_v = 3'b111;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] op, input string tag);
    int n;
    logic [3:0] nib;
    n = bqpi[sel] ? 2 : 8;
    for (int i = 0; i < n; i++) begin
      nib = bqpi[sel] ? ((i == 0) ? op[7:4] : op[3:0]) : {3'b000, op[7-i]};
      sck_cycle(nib);
      checks++;
      if (sel_oe !== 1'b0) begin
        errors++;
        $display("FAIL %s cmd_oe: dio_oe=%b expected 0", tag, sel_oe);
      end
    end
  endtask

  task automatic send_addr(input int a, input string tag);
    for (int i = 0; i < 6; i++) begin
      sck_cycle(4'(a >> (20 - 4 * i)));
      checks++;
      if (sel_oe !== 1'b0) begin
        errors++;
        $display("FAIL %s addr_oe: dio_oe=%b expected 0", tag, sel_oe);
      end
    end
  endtask

  task automatic do_write(input int a, input string tag);
    int p;
    p = a;
    begin_txn();
    send_cmd(8'h38, tag);
    send_addr(a, tag);
    foreach (wbuf[i]) begin
      sck_cycle(wbuf[i][7:4]);
      sck_cycle(wbuf[i][3:0]);
      mdl[sel][p] = wbuf[i];
      p = model_next(sel, p);
    end
    end_txn();
  endtask

  task automatic do_read(input int a, input int n, input string tag);
    int p;
    logic [7:0] got;
    logic [7:0] expb;
    p = a;
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mdl[sel][p]);
      p = model_next(sel, p);
    end
    begin_txn();
    send_cmd(8'hEB, tag);
    send_addr(a, tag);
    for (int i = 0; i < DUMMY - 1; i++) begin
      sck_cycle(4'h0);
      checks++;
      if (sel_oe !== 1'b0) begin
        errors++;
        $display("FAIL %s dummy_oe[%0d]: dio_oe=%b expected 0", tag, i, sel_oe);
      end
    end
    for (int i = 0; i < 2 * n; i++) begin
      sck_cycle(4'h0);
      checks++;
      if (sel_oe !== 1'b1) begin
        errors++;
        $display("FAIL %s read_oe[%0d]: dio_oe=%b expected 1", tag, i, sel_oe);
      end
      if (i % 2 == 0) begin
        got[7:4] = sel_out;
      end else begin
        got[3:0] = sel_out;
        expb = exp_q.pop_front();
        checks++;
        if (got !== expb) begin
          errors++;
          $display("FAIL %s read_byte[%0d]: got %h expected %h", tag, i / 2, got, expb);
        end
      end
    end
    end_txn();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({out0, out1, out2} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dio_out: got %h expected 000", {out0, out1, out2});
    end
    checks++;
    if ({oe0, oe1, oe2} !== 3'b000) begin
      errors++;
      $display("FAIL reset_dio_oe: got %b expected 000", {oe0, oe1, oe2});
    end
    checks++;
    if ({qpi0, qpi1, qpi2} !== 3'b000) begin
      errors++;
      $display("FAIL reset_qpi: got %b expected 000", {qpi0, qpi1, qpi2});
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_spi_rw();
    sel = 0;
    wbuf = '{8'hA5, 8'h3C};
    do_write(32'h10, "spi_wr");
    do_read(32'h10, 2, "spi_rd");
  endtask

  task automatic test_page_wrap();
    sel = 0;
    wbuf = '{8'h5A};
    do_write(32'h400, "wrap_pre");
    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(32'h3FE, "wrap_wr");
    do_read(32'h3FE, 2, "wrap_top");
    do_read(32'h000, 2, "wrap_base");
    do_read(32'h400, 1, "wrap_next_page");
    sel = 1;
    wbuf = '{8'hC3};
    do_write(32'h000, "lin_pre");
    wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_write(32'h3FE, "lin_wr");
    do_read(32'h3FE, 4, "lin_rd");
    do_read(32'h000, 1, "lin_base");
  endtask

  task automatic test_partial_write();
    sel = 0;
    wbuf = '{8'h00, 8'h99};
    do_write(32'h20, "part_pre");
    begin_txn();
    send_cmd(8'h38, "part_wr");
    send_addr(32'h20, "part_wr");
    sck_cycle(4'h7);
    sck_cycle(4'hE);
    sck_cycle(4'h9);
    end_txn();
    mdl[0][32'h20] = 8'h7E;
    do_read(32'h20, 2, "part_rd");
  endtask

  task automatic test_qpi();
    sel = 0;
    begin_txn(); send_cmd(8'h35, "qpi_enter"); end_txn();
    bqpi[0] = 1'b1;
    checks++;
    if (qpi0 !== 1'b1) begin
      errors++;
      $display("FAIL qpi_enter: qpi_mode=%b expected 1", qpi0);
    end
    do_read(32'h10, 1, "qpi_rd");
    begin_txn(); send_cmd(8'hF5, "qpi_exit"); end_txn();
    bqpi[0] = 1'b0;
    checks++;
    if (qpi0 !== 1'b0) begin
      errors++;
      $display("FAIL qpi_exit: qpi_mode=%b expected 0", qpi0);
    end
    sel = 2;
    begin_txn(); send_cmd(8'h35, "noqpi_enter"); end_txn();
    checks++;
    if (qpi2 !== 1'b0) begin
      errors++;
      $display("FAIL noqpi_enter: qpi_mode=%b expected 0", qpi2);
    end
  endtask

  task automatic test_reset_seq();
    sel = 0;
    begin_txn(); send_cmd(8'h35, "rs_enter"); end_txn();
    bqpi[0] = 1'b1;
    begin_txn(); send_cmd(8'h99, "rs_alone"); end_txn();
    checks++;
    if (qpi0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_alone: qpi_mode=%b expected 1", qpi0);
    end
    begin_txn(); send_cmd(8'h66, "rs_en"); end_txn();
    begin_txn(); send_cmd(8'h99, "rs_rst"); end_txn();
    bqpi[0] = 1'b0;
    checks++;
    if (qpi0 !== 1'b0) begin
      errors++;
      $display("FAIL rst_pair: qpi_mode=%b expected 0", qpi0);
    end
    begin_txn(); send_cmd(8'h35, "rs_enter2"); end_txn();
    bqpi[0] = 1'b1;
    begin_txn();
    send_cmd(8'hEB, "rs_midread");
    send_addr(32'h10, "rs_midread");
    for (int i = 0; i < DUMMY + 1; i++) sck_cycle(4'h0);
    checks++;
    if (oe0 !== 1'b1) begin
      errors++;
      $display("FAIL midread_active: dio_oe=%b expected 1", oe0);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (oe0 !== 1'b0) begin
      errors++;
      $display("FAIL midread_reset_oe: dio_oe=%b expected 0", oe0);
    end
    checks++;
    if (qpi0 !== 1'b0) begin
      errors++;
      $display("FAIL midread_reset_qpi: qpi_mode=%b expected 0", qpi0);
    end
    repeat (3) @(negedge clk);
    ce_n_v = 3'b111;
    resetn = 1'b1;
    bqpi[0] = 1'b0;
    repeat (8) @(negedge clk);
    do_read(32'h10, 2, "after_reset");
  endtask

  task automatic test_unsupported();
    sel = 0;
    begin_txn();
    send_cmd(8'h03, "unsup");
    for (int i = 0; i < 20; i++) begin
      sck_cycle(4'($urandom_range(0, 15)));
      checks++;
      if (oe0 !== 1'b0) begin
        errors++;
        $display("FAIL unsup_oe[%0d]: dio_oe=%b expected 0", i, oe0);
      end
    end
    end_txn();
    do_read(32'h10, 2, "unsup_mem10");
    do_read(32'h20, 2, "unsup_mem20");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spi_rw();
    test_page_wrap();
    test_partial_write();
    test_qpi();
    test_reset_seq();
    test_unsupported();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
